// File: rtl/id_ex_stage_if.sv
// ID-to-EX pipeline bundle: decoded fields from ID and their registered copies
// presented to EX and the forwarding unit.
interface id_ex_stage_if #(
   parameter int unsigned XLEN = 64
);
   logic            id_valid;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_rs1_data;
   logic [XLEN-1:0] id_rs2_data;
   logic [XLEN-1:0] id_imm;
   logic [4:0]      id_rs1;
   logic [4:0]      id_rs2;
   logic [4:0]      id_rd;
   logic [3:0]      id_funct4;
   logic            id_reg_write;
   logic            id_mem_read;
   logic            id_mem_write;
   logic            id_mem_to_reg;
   logic            id_branch;
   logic            id_alu_src;
   logic [1:0]      id_alu_op;

   logic            IDEX_valid;
   logic [XLEN-1:0] IDEX_pc;
   logic [XLEN-1:0] IDEX_rs1_data;
   logic [XLEN-1:0] IDEX_rs2_data;
   logic [XLEN-1:0] IDEX_imm;
   logic [4:0]      IDEX_rs1;
   logic [4:0]      IDEX_rs2;
   logic [4:0]      IDEX_rd;
   logic [3:0]      IDEX_funct4;
   logic            IDEX_reg_write;
   logic            IDEX_mem_read;
   logic            IDEX_mem_write;
   logic            IDEX_mem_to_reg;
   logic            IDEX_branch;
   logic            IDEX_alu_src;
   logic [1:0]      IDEX_alu_op;

   modport master (
      output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
             id_rs1, id_rs2, id_rd, id_funct4,
             id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
             id_branch, id_alu_src, id_alu_op,
      input  IDEX_valid, IDEX_pc, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm,
             IDEX_rs1, IDEX_rs2, IDEX_rd, IDEX_funct4,
             IDEX_reg_write, IDEX_mem_read, IDEX_mem_write, IDEX_mem_to_reg,
             IDEX_branch, IDEX_alu_src, IDEX_alu_op
   );

   modport slave (
      input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
             id_rs1, id_rs2, id_rd, id_funct4,
             id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
             id_branch, id_alu_src, id_alu_op,
      output IDEX_valid, IDEX_pc, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm,
             IDEX_rs1, IDEX_rs2, IDEX_rd, IDEX_funct4,
             IDEX_reg_write, IDEX_mem_read, IDEX_mem_write, IDEX_mem_to_reg,
             IDEX_branch, IDEX_alu_src, IDEX_alu_op
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, branch squash, global hold
// and a saturating load-use stall counter.
module id_ex_stage #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   id_ex_stage_if.slave     bus,
   input  logic             hold,
   input  logic             flush,
   output logic             stall,
   output logic [CNT_W-1:0] stall_count
);

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [3:0]      funct4;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            mem_to_reg;
      logic            branch;
      logic            alu_src;
      logic [1:0]      alu_op;
   } idex_t;

   idex_t r_q;
   idex_t r_d;
   logic  load_use;

   assign load_use = r_q.valid & r_q.mem_read & (r_q.rd != 5'd0) & bus.id_valid &
                     ((r_q.rd == bus.id_rs1) | (r_q.rd == bus.id_rs2));

   assign stall = load_use & ~flush & ~hold;

   // Flush and a load-use stall both turn the captured instruction into an all-zero bubble.
   always_comb begin
      r_d            = '0;
      r_d.valid      = bus.id_valid;
      r_d.pc         = bus.id_pc;
      r_d.rs1_data   = bus.id_rs1_data;
      r_d.rs2_data   = bus.id_rs2_data;
      r_d.imm        = bus.id_imm;
      r_d.rs1        = bus.id_rs1;
      r_d.rs2        = bus.id_rs2;
      r_d.rd         = bus.id_rd;
      r_d.funct4     = bus.id_funct4;
      r_d.reg_write  = bus.id_valid & bus.id_reg_write;
      r_d.mem_read   = bus.id_valid & bus.id_mem_read;
      r_d.mem_write  = bus.id_valid & bus.id_mem_write;
      r_d.mem_to_reg = bus.id_valid & bus.id_mem_to_reg;
      r_d.branch     = bus.id_valid & bus.id_branch;
      r_d.alu_src    = bus.id_valid & bus.id_alu_src;
      r_d.alu_op     = bus.id_valid ? bus.id_alu_op : 2'b00;
      if (flush || load_use) begin
         r_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q         <= '0;
         stall_count <= '0;
      end else begin
         if (flush || !hold) begin
            r_q <= r_d;
         end
         if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
         end
      end
   end

   assign bus.IDEX_valid      = r_q.valid;
   assign bus.IDEX_pc         = r_q.pc;
   assign bus.IDEX_rs1_data   = r_q.rs1_data;
   assign bus.IDEX_rs2_data   = r_q.rs2_data;
   assign bus.IDEX_imm        = r_q.imm;
   assign bus.IDEX_rs1        = r_q.rs1;
   assign bus.IDEX_rs2        = r_q.rs2;
   assign bus.IDEX_rd         = r_q.rd;
   assign bus.IDEX_funct4     = r_q.funct4;
   assign bus.IDEX_reg_write  = r_q.reg_write;
   assign bus.IDEX_mem_read   = r_q.mem_read;
   assign bus.IDEX_mem_write  = r_q.mem_write;
   assign bus.IDEX_mem_to_reg = r_q.mem_to_reg;
   assign bus.IDEX_branch     = r_q.branch;
   assign bus.IDEX_alu_src    = r_q.alu_src;
   assign bus.IDEX_alu_op     = r_q.alu_op;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register with integrated load-use interlock for the 5-stage RISC-V core. It captures decoded operands and control from ID each cycle and presents them to EX and to forwarding_unit (IDEX_rs1/IDEX_rs2). It detects load-use hazards, stalls PC and IF/ID for one cycle, and inserts a bubble. It also squashes on a taken branch and counts stall cycles for performance monitoring.

Parameters:
XLEN, 64, datapath width of PC, operands and immediate
CNT_W, 32, width of saturating stall counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1_data  in  XLEN  register-file read 1
id_rs2_data  in  XLEN  register-file read 2
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  5  source register 1
id_rs2  in  5  source register 2
id_rd  in  5  destination register
id_funct4  in  4  {funct7[5], funct3}
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch, id_alu_src  in  1 each  decoded control
id_alu_op  in  2  ALU op class
hold  in  1  global freeze (memory busy); all registers keep value
flush  in  1  taken branch resolved in EX; squash ID instruction
IDEX_valid  out  1  EX holds a real instruction
IDEX_pc, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm  out  XLEN  registered copies
IDEX_rs1, IDEX_rs2, IDEX_rd  out  5  registered register indices (to forwarding_unit)
IDEX_funct4  out  4  registered
IDEX_reg_write, IDEX_mem_read, IDEX_mem_write, IDEX_mem_to_reg, IDEX_branch, IDEX_alu_src  out  1 each  registered control
IDEX_alu_op  out  2  registered
stall  out  1  combinational: freeze PC and IF/ID this cycle
stall_count  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (rst_n=0, async): every registered output, including stall_count, is 0. stall therefore evaluates to 0.
- load_use (combinational) = IDEX_valid & IDEX_mem_read & (IDEX_rd!=0) & id_valid & (IDEX_rd==id_rs1 | IDEX_rd==id_rs2).
- stall = load_use & ~flush & ~hold. Under hold the upstream is frozen externally; under flush the ID instruction dies anyway.
- Per rising edge, priority order:
  1. flush=1: load bubble (IDEX_valid=0, all IDEX control bits and alu_op=0; data/index fields 0). flush wins over hold.
  2. hold=1: all registers unchanged, stall_count unchanged.
  3. load_use=1: load bubble; stall_count += 1, saturating at all-ones.
  4. Otherwise: load all id_* fields. IDEX_valid=id_valid. If id_valid=0, control bits load as 0.
- Latency: exactly 1 cycle from id_* to IDEX_*. A load-use stall lasts exactly 1 cycle, because the bubble clears IDEX_mem_read. A load followed by a dependent load stalls once per pair.
- rd=x0 never triggers a stall. rs1 and rs2 both matching still gives a single stall.
- Bubble is all-zero control, so forwarding_unit and later stages see no register write.
- Reset asserted mid-stall: outputs go to 0 immediately. The stall releases on the same cycle (combinational through IDEX_valid=0).

Test Plan:
- Reset: hold rst_n=0 with random id_* -> all IDEX_* =0, stall=0, stall_count=0. Release, id_valid=1 add x3,x1,x2 -> next edge IDEX_rd=3, IDEX_reg_write=1, IDEX_valid=1.
- Load-use: ld x5,0(x1) then add x6,x5,x2 -> stall=1 for exactly one cycle. Next edge IDEX_valid=0 with control 0. The following edge IDEX_rd=6. stall_count=1.
- x0 and non-dependent: ld x0 then add x6,x0,x2 -> stall never asserts. ld x5 then add x6,x7,x8 -> no stall.
- Flush priority: load-use condition present with flush=1 -> stall=0, bubble loaded, stall_count unchanged. Repeat with hold=1 as well -> flush still loads bubble.
- Hold: hold=1 for 3 cycles with changing id_* -> IDEX_* and stall_count constant, stall=0. On release the current id_* are captured.
- Saturation: CNT_W=3, force 9 consecutive load-use pairs -> stall_count stops at 7. Async reset mid-stall -> stall drops to 0 without a clock edge.
